// File: rtl/aximm_csr_pkg.sv
// Register map and status-bit layout for the AXI-MM-over-AIB test-control responder.
// Offsets are relative to the responder's base address.
package aximm_csr_pkg;

    localparam logic [31:0] REG_MM_WR_CFG     = 32'h0000_1000;
    localparam logic [31:0] REG_MM_WR_RD_ADDR = 32'h0000_1004;
    localparam logic [31:0] REG_MM_BUS_STS    = 32'h0000_1008;
    localparam logic [31:0] REG_LINKUP_STS    = 32'h0000_100C;
    localparam logic [31:0] REG_MM_RD_CFG     = 32'h0000_1010;
    localparam logic [31:0] REG_DLY_X         = 32'h0000_2000;
    localparam logic [31:0] REG_DLY_Y         = 32'h0000_2004;
    localparam logic [31:0] REG_DLY_Z         = 32'h0000_2008;
    localparam logic [31:0] REG_DOUT_FIRST    = 32'h0000_4000;
    localparam logic [31:0] REG_DOUT_LAST     = 32'h0000_4010;
    localparam logic [31:0] REG_DIN_FIRST     = 32'h0000_4020;
    localparam logic [31:0] REG_DIN_LAST      = 32'h0000_4030;

    // The four captured 128-bit words occupy one 64-byte window starting at 0x4000.
    localparam logic [25:0] CAPT_WINDOW = 26'h000_0100;

    localparam int STS_CMP_PASS    = 0;
    localparam int STS_TEST_CMPL   = 1;
    localparam int STS_RD_ALIGN_OK = 2;
    localparam int STS_WR_ALIGN_OK = 3;
    localparam int STS_WR_DONE     = 4;
    localparam int STS_RD_DONE     = 5;

    function automatic logic [31:0] word_sel(input logic [127:0] data, input logic [1:0] k);
        logic [31:0] w;
        case (k)
            2'd0:    w = data[31:0];
            2'd1:    w = data[63:32];
            2'd2:    w = data[95:64];
            default: w = data[127:96];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aximm_csr_edge.sv
// Rising-edge detector for a level-held request. The previous level resets high
// so a request already asserted when reset releases is not treated as new.
module aximm_csr_edge (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b1;
        else     prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/aximm_csr_resp.sv
// Test-control register responder: decodes edge-triggered AVMM requests, holds
// the traffic-generator configuration and returns status/captured data with a two-cycle read.
module aximm_csr_resp
    import aximm_csr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h5000_0000,
    parameter logic [31:0] DLY_X_RST = 32'h0000_000C,
    parameter logic [31:0] DLY_Y_RST = 32'h0000_0020,
    parameter logic [31:0] DLY_Z_RST = 32'h0000_1770
) (
    input  logic         avmm_clk,
    input  logic         avmm_rst,
    input  logic         i_wren,
    input  logic         i_rden,
    input  logic [31:0]  i_wr_addr,
    input  logic [31:0]  i_wrdata,
    output logic [31:0]  o_master_readdata,
    output logic         o_master_readdatavalid,
    output logic         o_master_waitrequest,
    input  logic [1:0]   i_tx_online,
    input  logic [1:0]   i_rx_online,
    input  logic         i_wr_done,
    input  logic         i_rd_done,
    input  logic         i_wr_align_ok,
    input  logic         i_rd_align_ok,
    input  logic         i_cmp_pass,
    input  logic         i_test_cmpl,
    input  logic [127:0] i_dout_first,
    input  logic [127:0] i_dout_last,
    input  logic [127:0] i_din_first,
    input  logic [127:0] i_din_last,
    output logic         o_wr_go,
    output logic         o_rd_go,
    output logic [31:0]  o_wr_cfg,
    output logic [31:0]  o_rd_cfg,
    output logic [31:0]  o_axi_addr,
    output logic [31:0]  o_dly_x,
    output logic [31:0]  o_dly_y,
    output logic [31:0]  o_dly_z
);

    logic        wr_rise;
    logic        rd_rise;
    logic [31:0] req_off;
    logic        wr_cfg_hit;
    logic        rd_cfg_hit;
    logic [31:0] rd_off_q;
    logic        rd_pend;
    logic        wr_done_q;
    logic        rd_done_q;
    logic [31:0] rd_mux;

    aximm_csr_edge u_wren_edge (
        .clk   (avmm_clk),
        .rst   (avmm_rst),
        .level (i_wren),
        .rise  (wr_rise)
    );

    aximm_csr_edge u_rden_edge (
        .clk   (avmm_clk),
        .rst   (avmm_rst),
        .level (i_rden),
        .rise  (rd_rise)
    );

    assign req_off    = i_wr_addr - BASE_ADDR;
    assign wr_cfg_hit = wr_rise && (req_off == REG_MM_WR_CFG);
    assign rd_cfg_hit = wr_rise && (req_off == REG_MM_RD_CFG);

    always_ff @(posedge avmm_clk) begin
        if (avmm_rst) begin
            o_wr_cfg               <= '0;
            o_rd_cfg               <= '0;
            o_axi_addr             <= '0;
            o_dly_x                <= DLY_X_RST;
            o_dly_y                <= DLY_Y_RST;
            o_dly_z                <= DLY_Z_RST;
            o_wr_go                <= 1'b0;
            o_rd_go                <= 1'b0;
            wr_done_q              <= 1'b0;
            rd_done_q              <= 1'b0;
            rd_off_q               <= '0;
            rd_pend                <= 1'b0;
            o_master_readdata      <= '0;
            o_master_readdatavalid <= 1'b0;
            o_master_waitrequest   <= 1'b0;
        end else begin
            o_wr_go <= wr_cfg_hit;
            o_rd_go <= rd_cfg_hit;

            if (wr_rise) begin
                case (req_off)
                    REG_MM_WR_CFG:     o_wr_cfg   <= i_wrdata;
                    REG_MM_WR_RD_ADDR: o_axi_addr <= i_wrdata;
                    REG_MM_RD_CFG:     o_rd_cfg   <= i_wrdata;
                    REG_DLY_X:         o_dly_x    <= i_wrdata;
                    REG_DLY_Y:         o_dly_y    <= i_wrdata;
                    REG_DLY_Z:         o_dly_z    <= i_wrdata;
                    default:           ;
                endcase
            end

            // Clearing on both the accept edge and the go pulse means a done
            // pulse coincident with either is swallowed: go always wins.
            if (wr_cfg_hit || o_wr_go) wr_done_q <= 1'b0;
            else if (i_wr_done)        wr_done_q <= 1'b1;

            if (rd_cfg_hit || o_rd_go) rd_done_q <= 1'b0;
            else if (i_rd_done)        rd_done_q <= 1'b1;

            o_master_readdatavalid <= 1'b0;
            if (rd_pend) begin
                o_master_readdata      <= rd_mux;
                o_master_readdatavalid <= 1'b1;
                o_master_waitrequest   <= 1'b0;
                rd_pend                <= 1'b0;
            end
            if (rd_rise) begin
                rd_off_q             <= req_off;
                rd_pend              <= 1'b1;
                o_master_waitrequest <= 1'b1;
            end
        end
    end

    // Evaluated one cycle after accept, so same-edge writes are already visible.
    always_comb begin
        rd_mux = '0;
        case (rd_off_q)
            REG_MM_WR_CFG:     rd_mux = o_wr_cfg;
            REG_MM_WR_RD_ADDR: rd_mux = o_axi_addr;
            REG_MM_RD_CFG:     rd_mux = o_rd_cfg;
            REG_DLY_X:         rd_mux = o_dly_x;
            REG_DLY_Y:         rd_mux = o_dly_y;
            REG_DLY_Z:         rd_mux = o_dly_z;
            REG_MM_BUS_STS: begin
                rd_mux[STS_CMP_PASS]    = i_cmp_pass;
                rd_mux[STS_TEST_CMPL]   = i_test_cmpl;
                rd_mux[STS_RD_ALIGN_OK] = i_rd_align_ok;
                rd_mux[STS_WR_ALIGN_OK] = i_wr_align_ok;
                rd_mux[STS_WR_DONE]     = wr_done_q;
                rd_mux[STS_RD_DONE]     = rd_done_q;
            end
            REG_LINKUP_STS:
                rd_mux = {28'b0, i_rx_online[1], i_tx_online[1], i_rx_online[0], i_tx_online[0]};
            default: begin
                if (rd_off_q[31:6] == CAPT_WINDOW && rd_off_q[1:0] == 2'b00) begin
                    case (rd_off_q[5:4])
                        2'd0:    rd_mux = word_sel(i_dout_first, rd_off_q[3:2]);
                        2'd1:    rd_mux = word_sel(i_dout_last,  rd_off_q[3:2]);
                        2'd2:    rd_mux = word_sel(i_din_first,  rd_off_q[3:2]);
                        default: rd_mux = word_sel(i_din_last,   rd_off_q[3:2]);
                    endcase
                end
            end
        endcase
    end

endmodule

// File: tb/tb_aximm_csr_resp.sv
// Directed plus randomized bench for aximm_csr_resp against a register-map model.
module tb_aximm_csr_resp;

    localparam logic [31:0] A_WR_CFG  = 32'h5000_1000;
    localparam logic [31:0] A_AXI     = 32'h5000_1004;
    localparam logic [31:0] A_BUS_STS = 32'h5000_1008;
    localparam logic [31:0] A_LINKUP  = 32'h5000_100C;
    localparam logic [31:0] A_RD_CFG  = 32'h5000_1010;
    localparam logic [31:0] A_DLY_X   = 32'h5000_2000;
    localparam logic [31:0] A_DLY_Y   = 32'h5000_2004;
    localparam logic [31:0] A_DLY_Z   = 32'h5000_2008;

    logic         clk = 1'b0;
    logic         rst;
    logic         wren, rden;
    logic [31:0]  addr, wrdata;
    logic [31:0]  readdata;
    logic         readdatavalid, waitrequest;
    logic [1:0]   tx_online, rx_online;
    logic         wr_done, rd_done, wr_align_ok, rd_align_ok, cmp_pass, test_cmpl;
    logic [127:0] dout_first, dout_last, din_first, din_last;
    logic         wr_go, rd_go;
    logic [31:0]  wr_cfg, rd_cfg, axi_addr, dly_x, dly_y, dly_z;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_wr_cfg, m_rd_cfg, m_axi, m_dx, m_dy, m_dz;
    bit          m_wr_done, m_rd_done;

    aximm_csr_resp dut (
        .avmm_clk               (clk),
        .avmm_rst               (rst),
        .i_wren                 (wren),
        .i_rden                 (rden),
        .i_wr_addr              (addr),
        .i_wrdata               (wrdata),
        .o_master_readdata      (readdata),
        .o_master_readdatavalid (readdatavalid),
        .o_master_waitrequest   (waitrequest),
        .i_tx_online            (tx_online),
        .i_rx_online            (rx_online),
        .i_wr_done              (wr_done),
        .i_rd_done              (rd_done),
        .i_wr_align_ok          (wr_align_ok),
        .i_rd_align_ok          (rd_align_ok),
        .i_cmp_pass             (cmp_pass),
        .i_test_cmpl            (test_cmpl),
        .i_dout_first           (dout_first),
        .i_dout_last            (dout_last),
        .i_din_first            (din_first),
        .i_din_last             (din_last),
        .o_wr_go                (wr_go),
        .o_rd_go                (rd_go),
        .o_wr_cfg               (wr_cfg),
        .o_rd_cfg               (rd_cfg),
        .o_axi_addr             (axi_addr),
        .o_dly_x                (dly_x),
        .o_dly_y                (dly_y),
        .o_dly_z                (dly_z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_wr_cfg = 0; m_rd_cfg = 0; m_axi = 0;
        m_dx = 32'h0C; m_dy = 32'h20; m_dz = 32'h1770;
        m_wr_done = 0; m_rd_done = 0;
    endtask

    function automatic logic [31:0] mread(input logic [31:0] a);
        logic [127:0] cap [4];
        int idx;
        cap = '{dout_first, dout_last, din_first, din_last};
        case (a)
            A_WR_CFG:  return m_wr_cfg;
            A_AXI:     return m_axi;
            A_RD_CFG:  return m_rd_cfg;
            A_DLY_X:   return m_dx;
            A_DLY_Y:   return m_dy;
            A_DLY_Z:   return m_dz;
            A_BUS_STS: return 32'(m_rd_done) * 32 + 32'(m_wr_done) * 16 + 32'(wr_align_ok) * 8
                            + 32'(rd_align_ok) * 4 + 32'(test_cmpl) * 2 + 32'(cmp_pass);
            A_LINKUP:  return 32'(rx_online[1]) * 8 + 32'(tx_online[1]) * 4
                            + 32'(rx_online[0]) * 2 + 32'(tx_online[0]);
            default: ;
        endcase
        if (a >= 32'h5000_4000 && a <= 32'h5000_403C && a % 4 == 0) begin
            idx = int'((a - 32'h5000_4000) / 4);
            return 32'(cap[idx / 4] >> (32 * (idx % 4)));
        end
        return 32'h0;
    endfunction

    task automatic mwrite(input logic [31:0] a, input logic [31:0] d);
        case (a)
            A_WR_CFG: begin m_wr_cfg = d; m_wr_done = 0; end
            A_AXI:    m_axi = d;
            A_RD_CFG: begin m_rd_cfg = d; m_rd_done = 0; end
            A_DLY_X:  m_dx = d;
            A_DLY_Y:  m_dy = d;
            A_DLY_Z:  m_dz = d;
            default:  ;
        endcase
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".wr_cfg"}, wr_cfg, m_wr_cfg);
        check({tag, ".rd_cfg"}, rd_cfg, m_rd_cfg);
        check({tag, ".axi"},    axi_addr, m_axi);
        check({tag, ".dly_x"},  dly_x, m_dx);
        check({tag, ".dly_y"},  dly_y, m_dy);
        check({tag, ".dly_z"},  dly_z, m_dz);
    endtask

    // done_phase: 0 none, 1 done pulse in the accept cycle, 2 in the go-pulse cycle
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int done_phase);
        addr = a; wrdata = d; wren = 1;
        if (done_phase == 1) begin wr_done = 1; rd_done = 1; end
        step();
        wren = 0; wr_done = 0; rd_done = 0;
        check("wr_go", {31'b0, wr_go}, {31'b0, a == A_WR_CFG});
        check("rd_go", {31'b0, rd_go}, {31'b0, a == A_RD_CFG});
        if (done_phase != 0) begin m_wr_done = 1; m_rd_done = 1; end
        mwrite(a, d);
        check_regs("wr");
        if (done_phase == 2) begin wr_done = 1; rd_done = 1; end
        step();
        wr_done = 0; rd_done = 0;
        check("wr_go_end", {31'b0, wr_go}, 32'h0);
        check("rd_go_end", {31'b0, rd_go}, 32'h0);
    endtask

    task automatic do_read(input logic [31:0] a, input string tag);
        logic [31:0] exp;
        exp = mread(a);
        addr = a; rden = 1;
        step();
        rden = 0;
        check({tag, ".wait_hi"},  {31'b0, waitrequest},   32'h1);
        check({tag, ".valid_lo"}, {31'b0, readdatavalid}, 32'h0);
        step();
        check({tag, ".valid"},    {31'b0, readdatavalid}, 32'h1);
        check({tag, ".wait_lo"},  {31'b0, waitrequest},   32'h0);
        check({tag, ".data"},     readdata, exp);
        step();
        check({tag, ".valid_end"}, {31'b0, readdatavalid}, 32'h0);
        check({tag, ".hold"},      readdata, exp);
    endtask

    task automatic pulse_done(input bit is_wr);
        if (is_wr) wr_done = 1; else rd_done = 1;
        step();
        wr_done = 0; rd_done = 0;
        if (is_wr) m_wr_done = 1; else m_rd_done = 1;
    endtask

    task automatic randomize_status();
        tx_online = 2'($urandom); rx_online = 2'($urandom);
        wr_align_ok = 1'($urandom); rd_align_ok = 1'($urandom);
        cmp_pass = 1'($urandom); test_cmpl = 1'($urandom);
        dout_first = {$urandom, $urandom, $urandom, $urandom};
        dout_last  = {$urandom, $urandom, $urandom, $urandom};
        din_first  = {$urandom, $urandom, $urandom, $urandom};
        din_last   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        logic [31:0] addrs [$];
        logic [31:0] a;
        int gos;

        rst = 1; wren = 0; rden = 0; addr = 0; wrdata = 0;
        tx_online = 0; rx_online = 0; wr_done = 0; rd_done = 0;
        wr_align_ok = 0; rd_align_ok = 0; cmp_pass = 0; test_cmpl = 0;
        dout_first = 0; dout_last = 0; din_first = 0; din_last = 0;
        model_reset();
        repeat (3) step();
        rst = 0;
        step();

        check_regs("reset");
        check("reset.readdata", readdata, 32'h0);
        check("reset.valid", {31'b0, readdatavalid}, 32'h0);
        check("reset.wait",  {31'b0, waitrequest},   32'h0);
        check("reset.go",    {30'b0, wr_go, rd_go},  32'h0);

        do_read(A_DLY_X, "dly_x_rst");
        do_read(A_DLY_Y, "dly_y_rst");
        do_read(A_DLY_Z, "dly_z_rst");
        do_write(A_DLY_X, 32'h55, 0);
        do_read(A_DLY_X, "dly_x_wr");

        // Held write: three cycles high, one go pulse
        addr = A_WR_CFG; wrdata = 32'h0004_1804; wren = 1;
        gos = 0;
        for (int i = 0; i < 3; i++) begin step(); gos += int'(wr_go); end
        wren = 0;
        for (int i = 0; i < 3; i++) begin step(); gos += int'(wr_go); end
        mwrite(A_WR_CFG, 32'h0004_1804);
        check("held_wr.go_count", 32'(gos), 32'd1);
        check("held_wr.cfg", wr_cfg, 32'h0004_1804);

        // Sticky done flags
        pulse_done(1);
        do_read(A_BUS_STS, "sts_done_set");
        do_write(A_WR_CFG, 32'h1234, 0);
        do_read(A_BUS_STS, "sts_done_clr");
        do_write(A_WR_CFG, 32'h5678, 1);
        do_read(A_BUS_STS, "sts_go_done_accept");
        do_write(A_RD_CFG, 32'h9ABC, 2);
        do_read(A_BUS_STS, "sts_go_done_pulse");
        pulse_done(0);
        do_read(A_BUS_STS, "sts_rd_done_set");

        // 128-bit readback, LSW first
        din_last = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        for (int k = 0; k < 4; k++) do_read(32'h5000_4030 + 32'(4 * k), "din_last");

        tx_online = 2'b11; rx_online = 2'b11;
        do_read(A_LINKUP, "linkup");
        check("linkup.value", readdata, 32'hF);
        do_read(32'h5000_3000, "unmapped");

        // Same-edge write and read: read returns post-write data
        addr = A_DLY_Y; wrdata = 32'hABCD; wren = 1; rden = 1;
        step();
        wren = 0; rden = 0;
        mwrite(A_DLY_Y, 32'hABCD);
        step();
        check("wr_rd_same.valid", {31'b0, readdatavalid}, 32'h1);
        check("wr_rd_same.data", readdata, 32'hABCD);
        step();

        // Randomized traffic
        addrs = {A_WR_CFG, A_AXI, A_BUS_STS, A_LINKUP, A_RD_CFG, A_DLY_X, A_DLY_Y, A_DLY_Z,
                 32'h5000_3000, 32'h5000_1014, 32'h6000_1000, 32'h5000_4002, 32'h5000_4040};
        for (int k = 0; k < 16; k++) addrs.push_back(32'h5000_4000 + 32'(4 * k));
        for (int it = 0; it < 250; it++) begin
            a = addrs[$urandom_range(addrs.size() - 1)];
            case ($urandom_range(5))
                0, 1: do_write(a, $urandom, int'($urandom_range(7) == 0 ? $urandom_range(1, 2) : 0));
                2, 3: do_read(a, "rand_rd");
                4:    pulse_done(1'($urandom));
                default: begin randomize_status(); step(); end
            endcase
        end

        // Reset one cycle after a read accept drops the read
        addr = A_DLY_X; rden = 1;
        step();
        rden = 0; rst = 1;
        step();
        rst = 0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            check("rst_mid_read.valid", {31'b0, readdatavalid}, 32'h0);
            check("rst_mid_read.wait",  {31'b0, waitrequest},   32'h0);
            step();
        end
        check_regs("rst_mid_read");

        // Requests held through reset release must not fire
        addr = A_WR_CFG; wrdata = 32'hDEAD; wren = 1; rden = 1; rst = 1;
        step(); step();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("held_rst.valid", {31'b0, readdatavalid}, 32'h0);
            check("held_rst.wait",  {31'b0, waitrequest},   32'h0);
            check("held_rst.go",    {31'b0, wr_go},         32'h0);
        end
        check("held_rst.cfg", wr_cfg, 32'h0);
        wren = 0; rden = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aximm_csr_resp.md
# aximm_csr_resp

Register-slave responder for the AXI-MM-over-AIB test harness. It decodes the level-held AVMM-style requests (`i_wren`/`i_rden`, 32-bit address and data) issued by the bench or host and holds the test-control registers: write/read test start, AXI base address, delay X/Y/Z. It returns status, link-up and captured first/last 128-bit data words with a single-cycle `o_readdatavalid` pulse. It sits between the host register port and the AXI-MM write/read traffic generators and checkers inside `aximm_aib_top`.

## Interface
- `BASE_ADDR`, 32'h5000_0000: upper address match; offsets are `addr - BASE_ADDR`.
- `DLY_X_RST`, 32'h0000_000C: delay X reset value.
- `DLY_Y_RST`, 32'h0000_0020: delay Y reset value.
- `DLY_Z_RST`, 32'h0000_1770: delay Z reset value.
- `avmm_clk` in 1: the only clock.
- `avmm_rst` in 1: synchronous, active-high reset.
- `i_wren` in 1: write request, level-held for ≥1 cycle.
- `i_rden` in 1: read request, level-held for ≥1 cycle.
- `i_wr_addr` in 32: byte address, used for both reads and writes.
- `i_wrdata` in 32: write data.
- `o_master_readdata` out 32: read data.
- `o_master_readdatavalid` out 1: one-cycle pulse marking valid read data.
- `o_master_waitrequest` out 1: high from read accept until the valid pulse.
- `i_tx_online`, `i_rx_online` in 2 each: [0] = leader, [1] = follower.
- `i_wr_done`, `i_rd_done` in 1: one-cycle completion pulses from the generators.
- `i_wr_align_ok`, `i_rd_align_ok`, `i_cmp_pass`, `i_test_cmpl` in 1: live status.
- `i_dout_first`, `i_dout_last`, `i_din_first`, `i_din_last` in 128: captured data words.
- `o_wr_go`, `o_rd_go` out 1: one-cycle start pulses.
- `o_wr_cfg`, `o_rd_cfg`, `o_axi_addr`, `o_dly_x`, `o_dly_y`, `o_dly_z` out 32: register contents.

## Operation
- **Request detection.** A request is accepted on the cycle `i_wren` or `i_rden` is high while its registered previous value is low (rising edge). Holding the level high issues no further requests.
- **Address match.** `i_wr_addr` must equal `BASE_ADDR + offset`.
- **Write map**
  - 0x1000 WR_CFG: also pulses `o_wr_go`.
  - 0x1004 AXI_ADDR.
  - 0x1010 RD_CFG: also pulses `o_rd_go`.
  - 0x2000, 0x2004, 0x2008: DLY_X, DLY_Y, DLY_Z.
  - All other addresses: write ignored.
- **Read map**
  - All write-map registers read back their contents.
  - 0x1008 BUS_STS = {26'b0, rd_done, wr_done, wr_align_ok, rd_align_ok, test_cmpl, cmp_pass}.
  - 0x100C LINKUP = {28'b0, rx_online[1], tx_online[1], rx_online[0], tx_online[0]}.
  - 0x4000–0x400C DOUT_FIRST, 0x4010–0x401C DOUT_LAST, 0x4020–0x402C DIN_FIRST, 0x4030–0x403C DIN_LAST. Word k (offset +4k) returns bits [32k+31:32k].
  - Unmapped addresses return 32'h0.
- **Done flags.** `wr_done` and `rd_done` are sticky: set by the matching done pulse, cleared by the matching go. If go and done arrive in the same cycle, go wins and the flag is cleared.
- **Simultaneous write and read edges.** The write commits first; the read returns post-write data.

## Timing
- **Write latency.** Register updates and go pulses appear 1 cycle after the accept edge.
- **Read latency.** Cycle 0 = accept: address captured, waitrequest rises. Cycle 1: mux output registered. Cycle 2: `o_master_readdatavalid` = 1 for exactly one cycle and waitrequest falls. `o_master_readdata` holds its value until the next read.
- **Read-data sampling.** Live status inputs are sampled at cycle 1.
- **Reset values.**
  - Configuration registers, `o_axi_addr`, readdata, valid, waitrequest, go pulses, done flags: all 0.
  - Delay registers: their `*_RST` parameters.
  - Previous-level registers reset to 1, so a request held high through reset does not fire.
- **Reset mid-read.** The pending read is dropped and no valid pulse is issued.

## Structure
- **Shared package `aximm_csr_pkg`.** Holds the offset localparams (`REG_MM_WR_CFG`, `REG_MM_WR_RD_ADDR`, `REG_MM_BUS_STS`, `REG_LINKUP_STS`, `REG_MM_RD_CFG`, `REG_DLY_X/Y/Z`, `REG_DOUT_FIRST`, …) and the BUS_STS bit-index constants.
- **Sub-module `aximm_csr_edge`.** Rising-edge detector with set-on-reset previous state, instantiated for wren and rden.

## Test plan
- **Delay writes.** After reset, read 0x50002000/04/08 → 0x0C, 0x20, 0x1770. Write 0x50002000 = 0x55 → readback 0x55.
- **Held write.** Hold `i_wren` for 3 cycles at 0x50001000 with data 0x00041804 → exactly one `o_wr_go` pulse and `o_wr_cfg` = 0x00041804.
- **Sticky done.** Pulse `i_wr_done`, then read 0x50001008 → bit4 = 1. A new write to WR_CFG → bit4 = 0. Go and done in the same cycle → bit4 = 0.
- **128-bit readback.** Set `i_din_last` = 0x0123…CDEF and read 0x50004030..3C → words LSW first, each valid 2 cycles after its accept edge.
- **Link-up.** Set tx/rx_online = 2'b11 and read 0x5000100C → 0xF. Read unmapped 0x50003000 → 0x0.
- **Reset behaviour.** Assert `avmm_rst` the cycle after a read accept → no valid pulse. Hold `i_rden` high through reset release → no read.
